// File: rtl/mul_div_seq.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) sequencer sharing one {hi, lo} accumulator.
// Stalls the pipeline via busy for WIDTH cycles; results are registered and pulse done for one cycle.
module mul_div_seq #(
  parameter int          WIDTH  = 32,
  parameter logic [3:0]  OP_MUL = 4'd11,
  parameter logic [3:0]  OP_DIV = 4'd12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       opSel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] resultExt,
  output logic             carryFlag,
  output logic             signFlag,
  output logic             zeroFlag
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state;
  logic [5:0]       cnt;
  // hi/lo hold {product high, multiplier/product low} for MUL and {remainder, quotient} for DIV
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] opnd;

  logic [WIDTH:0]   mulSum;
  logic [WIDTH-1:0] mulHiNxt;
  logic [WIDTH-1:0] mulLoNxt;
  logic [WIDTH:0]   divShift;
  logic [WIDTH:0]   divTrial;
  logic [WIDTH-1:0] divRemNxt;
  logic [WIDTH-1:0] divQuoNxt;
  logic             lastIter;

  always_comb begin
    mulSum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    mulHiNxt = mulSum[WIDTH:1];
    mulLoNxt = {mulSum[0], lo[WIDTH-1:1]};

    // rem < divisor keeps the WIDTH+1-bit trial MSB a valid sign bit
    divShift = {hi, lo[WIDTH-1]};
    divTrial = divShift - {1'b0, opnd};
    if (!divTrial[WIDTH]) begin
      divRemNxt = divTrial[WIDTH-1:0];
      divQuoNxt = {lo[WIDTH-2:0], 1'b1};
    end else begin
      divRemNxt = divShift[WIDTH-1:0];
      divQuoNxt = {lo[WIDTH-2:0], 1'b0};
    end

    lastIter = (cnt == 6'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      hi        <= '0;
      lo        <= '0;
      opnd      <= '0;
      result    <= '0;
      resultExt <= '0;
      carryFlag <= 1'b0;
      signFlag  <= 1'b0;
      zeroFlag  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start && opSel == OP_MUL) begin
            hi    <= '0;
            lo    <= b;
            opnd  <= a;
            cnt   <= '0;
            state <= MUL;
          end else if (start && opSel == OP_DIV) begin
            hi   <= '0;
            lo   <= a;
            opnd <= b;
            cnt  <= '0;
            if (b == '0) begin
              state     <= DONE;
              result    <= '1;
              resultExt <= a;
              carryFlag <= 1'b1;
              signFlag  <= 1'b1;
              zeroFlag  <= 1'b0;
            end else begin
              state <= DIV;
            end
          end
        end

        MUL: begin
          hi  <= mulHiNxt;
          lo  <= mulLoNxt;
          cnt <= cnt + 6'd1;
          if (lastIter) begin
            state     <= DONE;
            result    <= mulLoNxt;
            resultExt <= mulHiNxt;
            carryFlag <= |mulHiNxt;
            signFlag  <= mulLoNxt[WIDTH-1];
            zeroFlag  <= ~|mulLoNxt;
          end
        end

        DIV: begin
          hi  <= divRemNxt;
          lo  <= divQuoNxt;
          cnt <= cnt + 6'd1;
          if (lastIter) begin
            state     <= DONE;
            result    <= divQuoNxt;
            resultExt <= divRemNxt;
            carryFlag <= 1'b0;
            signFlag  <= divQuoNxt[WIDTH-1];
            zeroFlag  <= ~|divQuoNxt;
          end
        end

        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == MUL) || (state == DIV);
  assign done = (state == DONE);

endmodule

// File: tb/tb_mul_div_seq.sv
// Bench for mul_div_seq: directed cases with literal expectations plus a randomized run,
// all outputs compared every cycle against an arithmetic reference model.
module tb_mul_div_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   opSel;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [W-1:0] resultExt;
  logic         carryFlag;
  logic         signFlag;
  logic         zeroFlag;

  mul_div_seq #(.WIDTH(W), .OP_MUL(4'd11), .OP_DIV(4'd12)) dut (
    .clk(clk), .rst(rst), .start(start), .opSel(opSel), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .resultExt(resultExt),
    .carryFlag(carryFlag), .signFlag(signFlag), .zeroFlag(zeroFlag)
  );

  always #5 clk = ~clk;

  int nChk = 0;
  int nErr = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nChk++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an op takes W busy cycles then one done cycle, results from plain arithmetic
  int           busyLeft = 0;
  bit           mDone = 1'b0;
  bit           mValid = 1'b0;
  logic [63:0]  prod;
  logic [W-1:0] pRes, pExt, eRes, eExt;
  bit           pCarry, eCarry;

  always @(posedge clk) begin
    if (rst) begin
      busyLeft = 0; mDone = 1'b0; mValid = 1'b1;
      eRes = '0; eExt = '0; eCarry = 1'b0;
    end else if (mDone) begin
      mDone = 1'b0;
    end else if (busyLeft > 0) begin
      busyLeft--;
      if (busyLeft == 0) begin
        mDone = 1'b1; eRes = pRes; eExt = pExt; eCarry = pCarry;
      end
    end else if (start && (opSel == 4'd11 || opSel == 4'd12)) begin
      if (opSel == 4'd11) begin
        prod = {32'b0, a} * {32'b0, b};
        pRes = prod[31:0]; pExt = prod[63:32]; pCarry = (pExt != 0);
        busyLeft = W;
      end else if (b == 0) begin
        mDone = 1'b1; eRes = '1; eExt = a; eCarry = 1'b1;
      end else begin
        pRes = a / b; pExt = a % b; pCarry = 1'b0;
        busyLeft = W;
      end
    end
  end

  always @(negedge clk) begin
    if (mValid) begin
      chk("busy", busy, busyLeft > 0);
      chk("done", done, mDone);
      chk("result", result, eRes);
      chk("resultExt", resultExt, eExt);
      chk("carryFlag", carryFlag, eCarry);
      chk("signFlag", signFlag, eRes[W-1]);
      chk("zeroFlag", zeroFlag, eRes == 0);
    end
  end

  // Launch at edge 0, then watch a fixed window counting busy cycles and done pulses
  task automatic runOp(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit holdStart, output int lat, output int bc, output int nDone);
    start = 1'b1; opSel = op; a = x; b = y;
    @(posedge clk); #1;
    if (!holdStart) begin
      start = 1'b0;
      opSel = 4'($urandom);
    end
    a = $urandom; b = $urandom;
    lat = 0; bc = 0; nDone = 0;
    for (int i = 1; i <= W + 8; i++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) begin
        nDone++;
        if (lat == 0) lat = i;
        start = 1'b0;
      end
    end
    @(posedge clk); #1;
  endtask

  int lat, bc, nd, cnt;

  initial begin
    rst = 1'b1; start = 1'b0; opSel = 4'd0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_resultExt", resultExt, 0);
    chk("rst_zero", zeroFlag, 1);
    @(posedge clk); #1;

    runOp(4'd11, 32'd7, 32'd6, 1'b0, lat, bc, nd);
    chk("mul7x6_lat", lat, 33);
    chk("mul7x6_busycycles", bc, 32);
    chk("mul7x6_ndone", nd, 1);
    chk("mul7x6_result", result, 42);
    chk("mul7x6_ext", resultExt, 0);
    chk("mul7x6_carry", carryFlag, 0);
    chk("mul7x6_zero", zeroFlag, 0);
    chk("model_mul7x6", eRes, 42);

    runOp(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, bc, nd);
    chk("mulmax_result", result, 32'h0000_0001);
    chk("mulmax_ext", resultExt, 32'hFFFF_FFFE);
    chk("mulmax_carry", carryFlag, 1);
    chk("mulmax_sign", signFlag, 0);
    chk("model_mulmax_ext", eExt, 32'hFFFF_FFFE);

    runOp(4'd12, 32'd100, 32'd7, 1'b0, lat, bc, nd);
    chk("div100_7_lat", lat, 33);
    chk("div100_7_result", result, 14);
    chk("div100_7_ext", resultExt, 2);
    chk("model_div100_7", eExt, 2);

    runOp(4'd12, 32'h8000_0000, 32'd1, 1'b0, lat, bc, nd);
    chk("divmsb_result", result, 32'h8000_0000);
    chk("divmsb_sign", signFlag, 1);

    runOp(4'd12, 32'd5, 32'd0, 1'b0, lat, bc, nd);
    chk("div0_lat", lat, 1);
    chk("div0_busycycles", bc, 0);
    chk("div0_result", result, 32'hFFFF_FFFF);
    chk("div0_ext", resultExt, 5);
    chk("div0_carry", carryFlag, 1);

    runOp(4'd11, 32'd3, 32'd3, 1'b1, lat, bc, nd);
    chk("hold_ndone", nd, 1);
    chk("hold_result", result, 9);

    start = 1'b1; opSel = 4'd9; a = 32'd1; b = 32'd2;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy || done) cnt++;
    end
    chk("add_ignored", cnt, 0);
    @(posedge clk); #1 start = 1'b0;

    start = 1'b1; opSel = 4'd12; a = 32'd1000000; b = 32'd3;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_result", result, 0);
    chk("abort_zero", zeroFlag, 1);
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk("abort_nodone", cnt, 0);
    @(posedge clk); #1;

    runOp(4'd11, 32'd2, 32'd2, 1'b0, lat, bc, nd);
    chk("mul2x2_result", result, 4);
    chk("mul2x2_ndone", nd, 1);

    // Randomized traffic: start storms, mixed opcodes, zero/small operands, rare resets
    for (int i = 0; i < 2000; i++) begin
      int r;
      rst   = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 7);
      opSel = (r < 3) ? 4'd11 : (r < 6) ? 4'd12 : (r == 6) ? 4'd9 : 4'($urandom);
      r = $urandom_range(0, 5);
      b = (r == 0) ? '0 : (r == 1) ? W'($urandom_range(0, 15)) : $urandom;
      r = $urandom_range(0, 3);
      a = (r == 0) ? W'($urandom_range(0, 255)) : $urandom;
      @(posedge clk); #1;
    end
    rst = 1'b0; start = 1'b0;
    repeat (W + 4) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", nErr, nChk);
    $finish;
  end
endmodule
